// File: rtl/sprite_arb_pkg.sv
// Shared definitions for the sprite RAM arbiter.
//   sched_state_e : scheduler state (RENDER favours the renderer, BLANK the CPU)
//   STAT_*        : bit positions inside the I/O status register
package sprite_arb_pkg;

   typedef enum logic {
      RENDER = 1'b0,
      BLANK  = 1'b1
   } sched_state_e;

   // Status register: overflow flag sits in the MSB of the data word,
   // FIFO level in the low STAT_LEVEL_W bits.
   localparam int unsigned STAT_LEVEL_LSB = 0;
   localparam int unsigned STAT_LEVEL_W   = 4;
   // Writing a 1 to this bit of the status register clears overflow.
   localparam int unsigned STAT_CLR_BIT   = 0;

endpackage

// File: rtl/sprite_wr_fifo.sv
// Posted-write FIFO for the sprite RAM arbiter.
// Ports:
//   clock, reset      : clock, asynchronous active-high reset (clears pointers/level)
//   push_i, wr_data_i : enqueue request and entry; ignored when full unless popping
//   pop_i             : dequeue request; ignored when empty
//   head_o            : entry at the head of the queue
//   level_o           : occupancy, 0..DEPTH
//   full_o, empty_o   : occupancy flags
module sprite_wr_fifo #(
   parameter int unsigned WIDTH = 25,
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           wr_data_i,
   input  logic                       pop_i,
   output logic [WIDTH-1:0]           head_o,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       full_o,
   output logic                       empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic             do_push, do_pop;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == LVL_W'(DEPTH));
   assign level_o = level_q;
   assign head_o  = mem_q[rd_ptr_q];

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible between the pointers.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/sprite_ram_arbiter.sv
// Arbitrates the single-port sprite attribute RAM between posted CPU I/O
// writes and renderer reads. CPU writes go through a small FIFO; a two-state
// scheduler favours the renderer during active video and drains the FIFO
// during vertical blank.
// Optional feature: define SPRITE_ARB_STARVE_EN to force a CPU drain after
// STARVE_LIMIT consecutive renderer grants with writes pending.
// Ports:
//   clock, reset                    : clock, asynchronous active-high reset
//   cpu_io_addr/write/wr_data       : CPU I/O write bus (sprite window + status)
//   cpu_io_rd_data                  : status read data (combinational)
//   vblank                          : vertical blank from video timing
//   rnd_req/rnd_addr                : renderer read request / address
//   rnd_ack                         : renderer granted this cycle
//   rnd_valid/rnd_data              : read return, one cycle after rnd_ack
//   ram_addr/we/wr_data, ram_rd_data: sprite RAM port (1-cycle read latency)
module sprite_ram_arbiter
   import sprite_arb_pkg::*;
#(
   parameter int unsigned       DATA_W       = 16,
   parameter int unsigned       ADDR_W       = 9,
   parameter int unsigned       FIFO_DEPTH   = 4,
   parameter logic [3:0]        SPR_BASE     = 4'h4,
   parameter logic [DATA_W-1:0] STATUS_ADDR  = 16'h5000,
   parameter int unsigned       STARVE_LIMIT = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] cpu_io_addr,
   input  logic              cpu_io_write,
   input  logic [DATA_W-1:0] cpu_io_wr_data,
   output logic [DATA_W-1:0] cpu_io_rd_data,
   input  logic              vblank,
   input  logic              rnd_req,
   input  logic [ADDR_W-1:0] rnd_addr,
   output logic              rnd_ack,
   output logic              rnd_valid,
   output logic [DATA_W-1:0] rnd_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wr_data,
   input  logic [DATA_W-1:0] ram_rd_data
);

   localparam int unsigned LVL_W   = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned ENTRY_W = ADDR_W + DATA_W;

   sched_state_e        state_q, state_d;
   logic                vb_q;
   logic                ovf_q, ovf_d;
   logic                rnd_valid_q;

   logic                spr_wr, stat_wr, stat_sel;
   logic                grant, pop, starve_force;
   logic [ENTRY_W-1:0]  fifo_head;
   logic [LVL_W-1:0]    fifo_level;
   logic                fifo_full, fifo_empty;

   // ---------------- CPU I/O decode ----------------
   assign spr_wr   = cpu_io_write && (cpu_io_addr[DATA_W-1 -: 4] == SPR_BASE);
   assign stat_sel = (cpu_io_addr == STATUS_ADDR);
   assign stat_wr  = cpu_io_write && stat_sel;

   always_comb begin
      cpu_io_rd_data = '0;
      if (stat_sel) begin
         cpu_io_rd_data[DATA_W-1] = ovf_q;
         cpu_io_rd_data[STAT_LEVEL_LSB +: STAT_LEVEL_W] = STAT_LEVEL_W'(fifo_level);
      end
   end

   // A new drop in the same cycle as a clear leaves the flag set.
   always_comb begin
      ovf_d = ovf_q;
      if (stat_wr && cpu_io_wr_data[STAT_CLR_BIT]) ovf_d = 1'b0;
      if (spr_wr && fifo_full && !pop)             ovf_d = 1'b1;
   end

   sprite_wr_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push_i    (spr_wr),
      .wr_data_i ({cpu_io_addr[ADDR_W-1:0], cpu_io_wr_data}),
      .pop_i     (pop),
      .head_o    (fifo_head),
      .level_o   (fifo_level),
      .full_o    (fifo_full),
      .empty_o   (fifo_empty)
   );

   // ---------------- starvation guard ----------------
`ifdef SPRITE_ARB_STARVE_EN
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
   logic [CNT_W-1:0] starve_q, starve_d;
   logic             at_limit;

   assign at_limit     = (starve_q == CNT_W'(STARVE_LIMIT));
   assign starve_force = (state_q == RENDER) && at_limit && !fifo_empty;

   always_comb begin
      starve_d = starve_q;
      if (state_q != RENDER || pop || fifo_empty) starve_d = '0;
      else if (grant && !at_limit)                starve_d = starve_q + CNT_W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) starve_q <= '0;
      else       starve_q <= starve_d;
   end
`else
   assign starve_force = 1'b0;
`endif

   // ---------------- scheduler ----------------
   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      pop     = 1'b0;
      case (state_q)
         RENDER: begin
            if (vb_q) state_d = BLANK;
            if (starve_force)     pop   = 1'b1;
            else if (rnd_req)     grant = 1'b1;
            else if (!fifo_empty) pop   = 1'b1;
         end
         BLANK: begin
            if (!vb_q) state_d = RENDER;
            if (!fifo_empty)      pop   = 1'b1;
            else if (rnd_req)     grant = 1'b1;
         end
         default: state_d = RENDER;
      endcase
      // State registers are already cleared, but the RAM must not see an
      // access while reset is still asserted.
      if (reset) begin
         grant = 1'b0;
         pop   = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= RENDER;
         vb_q        <= 1'b0;
         ovf_q       <= 1'b0;
         rnd_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         vb_q        <= vblank;
         ovf_q       <= ovf_d;
         rnd_valid_q <= grant;
      end
   end

   // ---------------- RAM port ----------------
   always_comb begin
      ram_addr    = '0;
      ram_we      = 1'b0;
      ram_wr_data = '0;
      if (grant) begin
         ram_addr = rnd_addr;
      end else if (pop) begin
         ram_we      = 1'b1;
         ram_addr    = fifo_head[DATA_W +: ADDR_W];
         ram_wr_data = fifo_head[DATA_W-1:0];
      end
   end

   assign rnd_ack   = grant;
   assign rnd_valid = rnd_valid_q;
   assign rnd_data  = ram_rd_data;

endmodule
